parity_stream_engine: RTL and testbench

- Parametrised successor to the team's single-word combinational parity cell.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and generates or checks per-word parity (even/odd selectable).
- Accumulates frame-level parity and keeps a saturating error counter.
- Sits between a byte/word source and a UART/link framer; one pipeline stage with full backpressure.

---
 rtl/parity_stream_engine_pkg.sv | 16 +
 rtl/parity_reduce.sv | 17 +
 rtl/parity_stream_engine.sv | 164 ++++++++++++++++
 tb/tb_parity_stream_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_stream_engine_pkg.sv
// Shared types and constants for the parity stream engine and its helpers.
package parity_stream_engine_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } pse_state_e;

  localparam int MODE_ODD_BIT = 0;
  localparam int MODE_CHK_BIT = 1;

  function automatic logic [31:0] sat_max(input int cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/parity_reduce.sv
// WIDTH-parametrised XOR reduction; combinational, shared with future CRC/ECC blocks.
module parity_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             par
);

  // XOR fold of every data bit
  always_comb begin
    par = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      par = par ^ data[i];
    end
  end

endmodule

// File: rtl/parity_stream_engine.sv
// Streaming per-word parity generate/check with frame parity and a saturating error count.
module parity_stream_engine
  import parity_stream_engine_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_mode,
  input  logic             check_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par,
  output logic             out_err,
  output logic             out_last,
  output logic             frame_valid,
  output logic             frame_par,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_count
);

  localparam int               LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  pse_state_e       state_r, state_nxt_s;
  logic [LEN_W-1:0] word_cnt_r, word_cnt_nxt_s, word_idx_s;
  logic [1:0]       mode_r, mode_nxt_s, mode_eff_s;
  logic             acc_par_r, acc_par_nxt_s, acc_sum_s;
  logic             word_par_s, par_bit_s, close_s, accept_s, emit_s;

  logic             out_valid_r, out_par_r, out_err_r, out_last_r, out_fpar_r;
  logic [WIDTH-1:0] out_data_r;
  logic             frame_valid_r, frame_par_r;
  logic [CNT_W-1:0] err_count_r;

  parity_reduce #(.WIDTH(WIDTH)) u_word_par (
    .data (in_data),
    .par  (word_par_s)
  );

  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;
  assign emit_s   = out_valid_r && out_ready;

  // Per-word datapath: effective mode, word position and running frame parity
  always_comb begin
    mode_eff_s = mode_r;
    if (state_r == ST_IDLE) begin
      mode_eff_s[MODE_ODD_BIT] = odd_mode;
      mode_eff_s[MODE_CHK_BIT] = check_mode;
      word_idx_s               = LEN_W'(1'b1);
      acc_sum_s                = word_par_s;
    end else begin
      word_idx_s = word_cnt_r + LEN_W'(1'b1);
      acc_sum_s  = acc_par_r ^ word_par_s;
    end
    par_bit_s = word_par_s ^ mode_eff_s[MODE_ODD_BIT];
    close_s   = in_last || (word_idx_s == LEN_MAX);
  end

  // Frame FSM next state; a forced close at MAX_LEN behaves exactly like in_last
  always_comb begin
    state_nxt_s    = state_r;
    word_cnt_nxt_s = word_cnt_r;
    mode_nxt_s     = mode_r;
    acc_par_nxt_s  = acc_par_r;
    case (state_r)
      ST_IDLE, ST_IN_FRAME: begin
        if (accept_s && close_s) begin
          state_nxt_s    = ST_IDLE;
          word_cnt_nxt_s = {LEN_W{1'b0}};
          acc_par_nxt_s  = 1'b0;
          mode_nxt_s     = mode_eff_s;
        end else if (accept_s) begin
          state_nxt_s    = ST_IN_FRAME;
          word_cnt_nxt_s = word_idx_s;
          acc_par_nxt_s  = acc_sum_s;
          mode_nxt_s     = mode_eff_s;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        word_cnt_nxt_s = {LEN_W{1'b0}};
        acc_par_nxt_s  = 1'b0;
      end
    endcase
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      word_cnt_r <= {LEN_W{1'b0}};
      mode_r     <= 2'b00;
      acc_par_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      word_cnt_r <= word_cnt_nxt_s;
      mode_r     <= mode_nxt_s;
      acc_par_r  <= acc_par_nxt_s;
    end
  end

  // Output stage: frame parity rides along with the closing word until it leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_par_r   <= 1'b0;
      out_err_r   <= 1'b0;
      out_last_r  <= 1'b0;
      out_fpar_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= in_data;
      out_par_r   <= par_bit_s;
      out_err_r   <= mode_eff_s[MODE_CHK_BIT] && (in_par != par_bit_s);
      out_last_r  <= close_s;
      out_fpar_r  <= acc_sum_s ^ mode_eff_s[MODE_ODD_BIT];
    end else if (emit_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Frame report and saturating error counter; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid_r <= 1'b0;
      frame_par_r   <= 1'b0;
      err_count_r   <= {CNT_W{1'b0}};
    end else begin
      frame_valid_r <= emit_s && out_last_r;
      if (emit_s && out_last_r) begin
        frame_par_r <= out_fpar_r;
      end
      if (clr_count) begin
        err_count_r <= {CNT_W{1'b0}};
      end else if (emit_s && out_err_r && (err_count_r != CNT_MAX)) begin
        err_count_r <= err_count_r + CNT_W'(1'b1);
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_par     = out_par_r;
  assign out_err     = out_err_r;
  assign out_last    = out_last_r;
  assign frame_valid = frame_valid_r;
  assign frame_par   = frame_par_r;
  assign err_count   = err_count_r;

endmodule

// File: tb/tb_parity_stream_engine.sv
// Self-checking bench: frame-level behavioural model plus directed literal checks and random traffic.
module tb_parity_stream_engine;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_SAT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             odd_mode = 1'b0, check_mode = 1'b0;
  logic             in_valid = 1'b0, in_par = 1'b0, in_last = 1'b0;
  logic [WIDTH-1:0] in_data = 8'h00;
  logic             out_ready = 1'b1, clr_count = 1'b0;
  logic             in_ready, out_valid, out_par, out_err, out_last, frame_valid, frame_par;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  parity_stream_engine #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .check_mode(check_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_par(out_par), .out_err(out_err), .out_last(out_last), .frame_valid(frame_valid),
    .frame_par(frame_par), .err_count(err_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame held as a list of words, parity by popcount
  int   frame_q[$];
  logic f_odd = 1'b0, f_chk = 1'b0;
  logic m_valid = 1'b0, m_par = 1'b0, m_err = 1'b0, m_last = 1'b0, m_fpar_pend = 1'b0;
  logic m_fv = 1'b0, m_fpar = 1'b0;
  int   m_data = 0, m_cnt = 0;

  function automatic logic word_parity(input int d);
    return (($countones(d[WIDTH-1:0]) % 2) == 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q.delete();
      m_valid = 1'b0; m_data = 0; m_par = 1'b0; m_err = 1'b0; m_last = 1'b0;
      m_fpar_pend = 1'b0; m_fv = 1'b0; m_fpar = 1'b0; m_cnt = 0;
    end else begin
      logic emit, acc, fp;
      emit = m_valid && out_ready;
      acc  = in_valid && (!m_valid || out_ready);
      if (clr_count) m_cnt = 0;
      else if (emit && m_err && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
      m_fv = emit && m_last;
      if (emit && m_last) m_fpar = m_fpar_pend;
      if (acc) begin
        if (frame_q.size() == 0) begin
          f_odd = odd_mode;
          f_chk = check_mode;
        end
        frame_q.push_back(int'(in_data));
        m_data  = int'(in_data);
        m_par   = word_parity(int'(in_data)) ^ f_odd;
        m_err   = f_chk && (in_par != m_par);
        m_last  = in_last || (frame_q.size() == MAX_LEN);
        fp = f_odd;
        foreach (frame_q[i]) fp = fp ^ word_parity(frame_q[i]);
        m_fpar_pend = fp;
        m_valid = 1'b1;
        if (m_last) frame_q.delete();
      end else if (emit) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    check("in_ready", in_ready, !m_valid || out_ready);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_par", out_par, m_par);
      check("out_err", out_err, m_err);
      check("out_last", out_last, m_last);
    end
    check("frame_valid", frame_valid, m_fv);
    check("frame_par", frame_par, m_fpar);
    check("err_count", err_count, m_cnt);
  end

  task automatic send(input logic [7:0] d, input logic p, input logic l);
    logic ok, ready_now;
    ok = 1'b0;
    @(negedge clk); #1;
    in_valid = 1'b1; in_data = d; in_par = p; in_last = l;
    for (int k = 0; k < 50 && !ok; k++) begin
      ready_now = !m_valid || out_ready;
      @(posedge clk);
      if (ready_now) ok = 1'b1;
      else #1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_err_count", err_count, 2'd0);
    check("rst_frame_par", frame_par, 1'b0);

    // even generate, single-word frames
    send(8'h07, 1'b0, 1'b1);
    @(negedge clk);
    check("gen_07_par", out_par, 1'b1);
    check("gen_07_err", out_err, 1'b0);
    send(8'h03, 1'b0, 1'b1);
    @(negedge clk);
    check("gen_03_par", out_par, 1'b0);

    // odd check
    odd_mode = 1'b1; check_mode = 1'b1;
    send(8'h03, 1'b0, 1'b1);
    @(negedge clk);
    check("chk_bad_err", out_err, 1'b1);
    check("chk_bad_par", out_par, 1'b1);
    @(negedge clk);
    check("chk_cnt1", err_count, 2'd1);
    send(8'h03, 1'b1, 1'b1);
    @(negedge clk);
    check("chk_good_err", out_err, 1'b0);
    @(negedge clk);
    check("chk_cnt_hold", err_count, 2'd1);

    // even three-word frame; odd_mode toggled mid-frame must be ignored
    odd_mode = 1'b0; check_mode = 1'b0;
    send(8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check("frm_last1", out_last, 1'b0);
    odd_mode = 1'b1;
    send(8'h02, 1'b0, 1'b0);
    @(negedge clk);
    check("frm_last2", out_last, 1'b0);
    check("frm_par2_even", out_par, 1'b1);
    send(8'h04, 1'b0, 1'b1);
    @(negedge clk);
    check("frm_last3", out_last, 1'b1);
    @(negedge clk);
    check("frm_fv", frame_valid, 1'b1);
    check("frm_fpar", frame_par, 1'b1);
    @(negedge clk);
    check("frm_fv_pulse", frame_valid, 1'b0);
    odd_mode = 1'b0;

    // forced close at MAX_LEN, then a fresh frame of MAX_LEN words
    send(8'h01, 1'b0, 1'b0); @(negedge clk); check("max_w1", out_last, 1'b0);
    send(8'h03, 1'b0, 1'b0); @(negedge clk); check("max_w2", out_last, 1'b0);
    send(8'h07, 1'b0, 1'b0); @(negedge clk); check("max_w3", out_last, 1'b0);
    send(8'h0F, 1'b0, 1'b0); @(negedge clk); check("max_w4", out_last, 1'b1);
    @(negedge clk);
    check("max_fv", frame_valid, 1'b1);
    check("max_fpar", frame_par, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) begin
      send(8'(8'h10 * (i + 1)), 1'b0, 1'b0);
      @(negedge clk);
      check("max_next", out_last, (i == MAX_LEN - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);

    // backpressure for three cycles
    #1 out_ready = 1'b0;
    send(8'hA5, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 8'h5A; in_par = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_data_hold", out_data, 8'hA5);
      check("bp_par_hold", out_par, 1'b0);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_release", out_data, 8'h5A);

    // saturation with CNT_W=2, then clear beating increments
    check_mode = 1'b1; odd_mode = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h01, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    check("sat_cnt", err_count, 2'd3);
    for (int i = 0; i < 2; i++) begin
      send(8'h01, 1'b0, 1'b1);
      clr_count = 1'b1;
      @(posedge clk); #1 clr_count = 1'b0;
      @(negedge clk);
      check("clr_wins", err_count, 2'd0);
    end

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom_range(0, 255));
      in_par     = 1'($urandom_range(0, 1));
      in_last    = ($urandom_range(0, 3) == 0);
      odd_mode   = 1'($urandom_range(0, 1));
      check_mode = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_count  = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
    repeat (2) @(negedge clk);

    // frame with an error and non-zero frame parity, then reset mid-frame
    odd_mode = 1'b1; check_mode = 1'b1;
    send(8'h01, 1'b1, 1'b1);
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_par", out_par, 1'b0);
    check("mid_rst_err", out_err, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_fv", frame_valid, 1'b0);
    check("mid_rst_fpar", frame_par, 1'b0);
    check("mid_rst_cnt", err_count, 2'd0);
    check("mid_rst_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    odd_mode = 1'b0; check_mode = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h80, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
